// File: rtl/lock_pkg.sv
// Shared constants for the PIN lock controller: protocol bytes, FSM state
// encoding and small helpers used when sizing and decoding.
package lock_pkg;

  localparam logic [7:0] ASCII_A = 8'h41;
  localparam logic [7:0] ASCII_C = 8'h43;
  localparam logic [7:0] ASCII_K = 8'h4B;
  localparam logic [7:0] ASCII_E = 8'h45;
  localparam logic [7:0] ASCII_T = 8'h54;
  localparam logic [7:0] ASCII_L = 8'h4C;
  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_9 = 8'h39;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_CHECK   = 3'd2,
    ST_OPEN    = 3'd3,
    ST_LOCKOUT = 3'd4
  } lock_state_e;

  // Largest of three timing values; sizes the shared timeout counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // True for the ASCII characters '0'..'9'.
  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by every timeout of the lock controller.
// It stops at zero; done is high while the count is zero.
module lock_timer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] cnt_r;

  // Count down from the loaded value and hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {WIDTH{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {WIDTH{1'b0}}) begin
      cnt_r <= cnt_r - {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done = (cnt_r == {WIDTH{1'b0}});

endmodule

// File: rtl/lock_access_ctrl.sv
// PIN-entry door lock controller. Accepts 'A' + four BCD digits from a UART
// receiver, opens the latch for a fixed time on a match, counts consecutive
// failures into a timed lockout and answers every event with one ack byte.
module lock_access_ctrl #(
  parameter logic [15:0] CODE                = 16'h1234,
  parameter int          OPEN_CYCLES         = 250_000_000,
  parameter int          BYTE_TIMEOUT_CYCLES = 150_000_000,
  parameter int          LOCKOUT_CYCLES      = 1_500_000_000,
  parameter int          MAX_FAILS           = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic       ack_ready,
  output logic       lock_open,
  output logic       locked_out,
  output logic       ack_valid,
  output logic [7:0] ack_byte
);

  import lock_pkg::*;

  localparam int MAX_T   = max3(OPEN_CYCLES, BYTE_TIMEOUT_CYCLES, LOCKOUT_CYCLES);
  localparam int TIMER_W = $clog2(MAX_T) + 1;
  localparam int FAIL_W  = $clog2(MAX_FAILS + 1);

  lock_state_e         state_r;
  lock_state_e         next_state_s;
  logic [15:0]         digit_buf_r;
  logic [1:0]          digit_cnt_r;
  logic [FAIL_W-1:0]   fail_cnt_r;
  logic [FAIL_W-1:0]   fail_sat_s;
  logic                is_digit_s;
  logic                pin_match_s;
  logic                shift_s;
  logic                restart_s;
  logic                clear_entry_s;
  logic                fail_inc_s;
  logic                fail_clr_s;
  logic                ack_load_s;
  logic [7:0]          ack_code_s;
  logic                timer_load_s;
  logic [TIMER_W-1:0]  timer_val_s;
  logic                timer_done_s;
  logic                lock_open_nxt_s;
  logic                locked_out_nxt_s;
  logic                ack_valid_nxt_s;
  logic [7:0]          ack_byte_nxt_s;
  logic                lock_open_r;
  logic                locked_out_r;
  logic                ack_valid_r;
  logic [7:0]          ack_byte_r;

  assign is_digit_s  = is_digit(rx_byte);
  assign pin_match_s = (digit_buf_r == CODE);
  // Failure count after one more failure, saturating at MAX_FAILS.
  assign fail_sat_s  = (fail_cnt_r == FAIL_W'(MAX_FAILS)) ? fail_cnt_r
                                                          : fail_cnt_r + {{(FAIL_W-1){1'b0}}, 1'b1};

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode together with the side effects of each transition.
  always_comb begin
    next_state_s  = state_r;
    shift_s       = 1'b0;
    restart_s     = 1'b0;
    clear_entry_s = 1'b0;
    fail_inc_s    = 1'b0;
    fail_clr_s    = 1'b0;
    ack_load_s    = 1'b0;
    ack_code_s    = 8'h00;
    case (state_r)
      ST_IDLE: begin
        if (rx_valid && (rx_byte == ASCII_A)) begin
          next_state_s  = ST_COLLECT;
          clear_entry_s = 1'b1;
        end else if (rx_valid && (rx_byte == ASCII_C)) begin
          ack_load_s = 1'b1;
          ack_code_s = ASCII_K;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (rx_valid) begin
          if (is_digit_s) begin
            shift_s   = 1'b1;
            restart_s = 1'b1;
            if (digit_cnt_r == 2'd3) begin
              next_state_s = ST_CHECK;
            end else begin
              next_state_s = ST_COLLECT;
            end
          end else if (rx_byte == ASCII_C) begin
            next_state_s = ST_IDLE;
            ack_load_s   = 1'b1;
            ack_code_s   = ASCII_K;
          end else begin
            next_state_s = ST_IDLE;
            ack_load_s   = 1'b1;
            ack_code_s   = ASCII_E;
            fail_inc_s   = 1'b1;
          end
        end else if (timer_done_s) begin
          next_state_s = ST_IDLE;
          ack_load_s   = 1'b1;
          ack_code_s   = ASCII_T;
        end else begin
          next_state_s = ST_COLLECT;
        end
      end
      ST_CHECK: begin
        ack_load_s = 1'b1;
        if (pin_match_s) begin
          next_state_s = ST_OPEN;
          fail_clr_s   = 1'b1;
          ack_code_s   = ASCII_K;
        end else if (fail_sat_s == FAIL_W'(MAX_FAILS)) begin
          next_state_s = ST_LOCKOUT;
          fail_clr_s   = 1'b1;
          ack_code_s   = ASCII_L;
        end else begin
          next_state_s = ST_IDLE;
          fail_inc_s   = 1'b1;
          ack_code_s   = ASCII_E;
        end
      end
      ST_OPEN: begin
        if (rx_valid && (rx_byte == ASCII_C)) begin
          next_state_s = ST_IDLE;
          ack_load_s   = 1'b1;
          ack_code_s   = ASCII_K;
        end else if (timer_done_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_OPEN;
        end
      end
      ST_LOCKOUT: begin
        if (rx_valid && (rx_byte == ASCII_A)) begin
          ack_load_s = 1'b1;
          ack_code_s = ASCII_L;
        end else if (rx_valid && (rx_byte == ASCII_C)) begin
          ack_load_s = 1'b1;
          ack_code_s = ASCII_K;
        end else begin
          ack_load_s = 1'b0;
        end
        if (timer_done_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_LOCKOUT;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode: next values of the registered outputs and ack handshake.
  always_comb begin
    lock_open_nxt_s  = (next_state_s == ST_OPEN);
    locked_out_nxt_s = (next_state_s == ST_LOCKOUT);
    if (ack_load_s) begin
      ack_valid_nxt_s = 1'b1;
      ack_byte_nxt_s  = ack_code_s;
    end else if (ack_valid_r && ack_ready) begin
      ack_valid_nxt_s = 1'b0;
      ack_byte_nxt_s  = ack_byte_r;
    end else begin
      ack_valid_nxt_s = ack_valid_r;
      ack_byte_nxt_s  = ack_byte_r;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_open_r  <= 1'b0;
      locked_out_r <= 1'b0;
      ack_valid_r  <= 1'b0;
      ack_byte_r   <= 8'h00;
    end else begin
      lock_open_r  <= lock_open_nxt_s;
      locked_out_r <= locked_out_nxt_s;
      ack_valid_r  <= ack_valid_nxt_s;
      ack_byte_r   <= ack_byte_nxt_s;
    end
  end

  // PIN digit buffer, digit count and consecutive-failure count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_buf_r <= 16'h0000;
      digit_cnt_r <= 2'd0;
      fail_cnt_r  <= {FAIL_W{1'b0}};
    end else begin
      if (clear_entry_s) begin
        digit_buf_r <= 16'h0000;
        digit_cnt_r <= 2'd0;
      end else if (shift_s) begin
        digit_buf_r <= {digit_buf_r[11:0], rx_byte[3:0]};
        digit_cnt_r <= digit_cnt_r + 2'd1;
      end else begin
        digit_buf_r <= digit_buf_r;
        digit_cnt_r <= digit_cnt_r;
      end
      if (fail_clr_s) begin
        fail_cnt_r <= {FAIL_W{1'b0}};
      end else if (fail_inc_s) begin
        fail_cnt_r <= fail_sat_s;
      end else begin
        fail_cnt_r <= fail_cnt_r;
      end
    end
  end

  // Timer reload: on every state change and on each digit inside COLLECT.
  // The loaded value is one less than the period so that done marks the
  // last cycle of the period.
  always_comb begin
    timer_load_s = (next_state_s != state_r) || restart_s;
    case (next_state_s)
      ST_COLLECT: timer_val_s = TIMER_W'(BYTE_TIMEOUT_CYCLES - 1);
      ST_OPEN:    timer_val_s = TIMER_W'(OPEN_CYCLES - 1);
      ST_LOCKOUT: timer_val_s = TIMER_W'(LOCKOUT_CYCLES - 1);
      default:    timer_val_s = {TIMER_W{1'b0}};
    endcase
  end

  lock_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load_s),
    .load_val (timer_val_s),
    .done     (timer_done_s)
  );

  assign lock_open  = lock_open_r;
  assign locked_out = locked_out_r;
  assign ack_valid  = ack_valid_r;
  assign ack_byte   = ack_byte_r;

endmodule

// File: tb/tb_lock_access_ctrl.sv
// Bench for lock_access_ctrl: a timestamp/queue based model checked every
// cycle, plus hand-computed literal checks on the directed scenarios.
module tb_lock_access_ctrl;

  localparam int OPEN_N = 100;
  localparam int TO_N   = 50;
  localparam int LOCK_N = 200;
  localparam int MAXF   = 3;
  localparam int PIN    = 16'h1234;

  localparam logic [7:0] CH_A = 8'h41;
  localparam logic [7:0] CH_C = 8'h43;
  localparam logic [7:0] CH_K = 8'h4B;
  localparam logic [7:0] CH_E = 8'h45;
  localparam logic [7:0] CH_T = 8'h54;
  localparam logic [7:0] CH_L = 8'h4C;

  localparam int M_IDLE = 0, M_COLLECT = 1, M_CHECK = 2, M_OPEN = 3, M_LOCK = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       ack_ready = 1'b1;
  logic       lock_open, locked_out, ack_valid;
  logic [7:0] ack_byte;

  int n_checks = 0;
  int n_pass   = 0;

  lock_access_ctrl #(
    .CODE                (16'h1234),
    .OPEN_CYCLES         (OPEN_N),
    .BYTE_TIMEOUT_CYCLES (TO_N),
    .LOCKOUT_CYCLES      (LOCK_N),
    .MAX_FAILS           (MAXF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .ack_ready  (ack_ready),
    .lock_open  (lock_open),
    .locked_out (locked_out),
    .ack_valid  (ack_valid),
    .ack_byte   (ack_byte)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  int         cyc = 0;
  int         m_mode = M_IDLE;
  int         m_digits[$];
  int         m_fails = 0;
  int         m_t0 = 0;
  bit         m_pend = 1'b0;
  logic [7:0] m_ack = 8'h00;

  task automatic model_step();
    bit         has;
    logic [7:0] nack;
    int         pin;
    cyc++;
    has  = 1'b0;
    nack = 8'h00;
    if (!rst_n) begin
      m_mode = M_IDLE; m_digits.delete(); m_fails = 0; m_pend = 1'b0; m_ack = 8'h00;
      return;
    end
    case (m_mode)
      M_IDLE: begin
        if (rx_valid && rx_byte == CH_A) begin
          m_mode = M_COLLECT; m_digits.delete(); m_t0 = cyc;
        end else if (rx_valid && rx_byte == CH_C) begin
          has = 1'b1; nack = CH_K;
        end
      end
      M_COLLECT: begin
        if (rx_valid) begin
          if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
            m_digits.push_back(int'(rx_byte) - 48);
            m_t0 = cyc;
            if (m_digits.size() == 4) m_mode = M_CHECK;
          end else if (rx_byte == CH_C) begin
            m_mode = M_IDLE; has = 1'b1; nack = CH_K;
          end else begin
            m_mode = M_IDLE; has = 1'b1; nack = CH_E;
            if (m_fails < MAXF) m_fails++;
          end
        end else if (cyc - m_t0 >= TO_N) begin
          m_mode = M_IDLE; has = 1'b1; nack = CH_T;
        end
      end
      M_CHECK: begin
        pin = 0;
        foreach (m_digits[i]) pin = pin * 16 + m_digits[i];
        has = 1'b1;
        if (pin == PIN) begin
          m_mode = M_OPEN; m_fails = 0; nack = CH_K; m_t0 = cyc;
        end else begin
          if (m_fails < MAXF) m_fails++;
          if (m_fails >= MAXF) begin
            m_mode = M_LOCK; m_fails = 0; nack = CH_L; m_t0 = cyc;
          end else begin
            m_mode = M_IDLE; nack = CH_E;
          end
        end
      end
      M_OPEN: begin
        if (rx_valid && rx_byte == CH_C) begin
          m_mode = M_IDLE; has = 1'b1; nack = CH_K;
        end else if (cyc - m_t0 >= OPEN_N) begin
          m_mode = M_IDLE;
        end
      end
      M_LOCK: begin
        if (rx_valid && rx_byte == CH_A) begin
          has = 1'b1; nack = CH_L;
        end else if (rx_valid && rx_byte == CH_C) begin
          has = 1'b1; nack = CH_K;
        end
        if (cyc - m_t0 >= LOCK_N) m_mode = M_IDLE;
      end
      default: m_mode = M_IDLE;
    endcase
    if (has) begin
      m_pend = 1'b1; m_ack = nack;
    end else if (m_pend && ack_ready) begin
      m_pend = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison of all outputs against the model.
  initial forever begin
    logic [10:0] exp_v;
    @(negedge clk);
    if (!rst_n) exp_v = 11'd0;
    else exp_v = {m_mode == M_OPEN, m_mode == M_LOCK, m_pend, m_ack};
    chk($sformatf("model_cmp@%0d", cyc), {21'd0, lock_open, locked_out, ack_valid, ack_byte},
        {21'd0, exp_v});
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic send_seq(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  // Full PIN entry followed by the CHECK cycle, so the result is visible.
  task automatic attempt(input string s);
    send_seq(s);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int xfers;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {21'd0, lock_open, locked_out, ack_valid, ack_byte}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Correct PIN: opens in the second cycle after '4', for exactly OPEN_N cycles.
    send_seq("A1234");
    chk("open_not_yet", {31'd0, lock_open}, 32'd0);
    @(negedge clk);
    chk("open_rise", {31'd0, lock_open}, 32'd1);
    chk("open_ack", {23'd0, ack_valid, ack_byte}, {23'd0, 1'b1, CH_K});
    cnt = 0;
    while (lock_open && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
    chk("open_duration", cnt, 32'd100);

    // 'C' during OPEN closes next cycle; other bytes are ignored.
    send_seq("A1234");
    @(negedge clk);
    send(8'h35);
    send(CH_A);
    repeat (6) @(negedge clk);
    chk("open_holds", {31'd0, lock_open}, 32'd1);
    send(CH_C);
    chk("close_c", {31'd0, lock_open}, 32'd0);
    chk("close_ack", {23'd0, ack_valid, ack_byte}, {23'd0, 1'b1, CH_K});

    // Inter-byte timeout.
    send_seq("A12");
    repeat (49) @(negedge clk);
    chk("timeout_not_yet", {31'd0, ack_valid}, 32'd0);
    @(negedge clk);
    chk("timeout_ack", {23'd0, ack_valid, ack_byte}, {23'd0, 1'b1, CH_T});
    attempt("A1234");
    chk("open_after_timeout", {31'd0, lock_open}, 32'd1);
    send(CH_C);

    // Failures counted, then cleared by a correct PIN; 'C' in IDLE acks 'K'.
    send(CH_C);
    chk("idle_c_ack", {24'd0, ack_byte}, {24'd0, CH_K});
    attempt("A1299");
    chk("wrong_ack", {23'd0, ack_valid, ack_byte}, {23'd0, 1'b1, CH_E});
    send_seq("A1X");
    chk("malformed_ack", {23'd0, ack_valid, ack_byte}, {23'd0, 1'b1, CH_E});
    attempt("A1234");
    chk("open_clears_fails", {31'd0, lock_open}, 32'd1);
    send(CH_C);

    // Three wrong PINs with the transmitter stalled: E, E, then L.
    ack_ready = 1'b0;
    attempt("A1299");
    chk("fail1_ack", {23'd0, ack_valid, ack_byte}, {23'd0, 1'b1, CH_E});
    attempt("A1299");
    chk("fail2_ack", {23'd0, ack_valid, ack_byte}, {23'd0, 1'b1, CH_E});
    attempt("A1299");
    chk("fail3_ack", {23'd0, ack_valid, ack_byte}, {23'd0, 1'b1, CH_L});
    chk("locked_out_set", {31'd0, locked_out}, 32'd1);
    attempt("A1234");
    chk("lockout_no_open", {30'd0, lock_open, locked_out}, 32'd1);
    chk("lockout_a_ack", {24'd0, ack_byte}, {24'd0, CH_L});
    ack_ready = 1'b1;
    xfers = 0;
    for (int i = 0; i < 5; i++) begin
      if (ack_valid && ack_ready) xfers++;
      @(negedge clk);
    end
    chk("single_transfer", xfers, 32'd1);
    send(CH_C);
    chk("lockout_c_ack", {23'd0, ack_valid, ack_byte}, {23'd0, 1'b1, CH_K});
    cnt = 0;
    while (locked_out && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
    chk("lockout_ends", {31'd0, locked_out}, 32'd0);
    attempt("A1234");
    chk("open_after_lockout", {31'd0, lock_open}, 32'd1);
    send(CH_C);

    // Asynchronous reset during OPEN.
    attempt("A1234");
    repeat (5) @(negedge clk);
    chk("open_before_reset", {31'd0, lock_open}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {21'd0, lock_open, locked_out, ack_valid, ack_byte}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_reset", {21'd0, lock_open, locked_out, ack_valid, ack_byte}, 32'd0);
    attempt("A1234");
    chk("open_after_reset", {31'd0, lock_open}, 32'd1);
    send(CH_C);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
